i11956_pattern_monitor: RTL and testbench
=========================================

Name: i11956_pattern_monitor

Overview:
- Small sequential benchmark cell for the trojan-detection test suite.
- Evaluates a fixed 4-input Boolean function and registers the result onto a single output.
- Contains a consecutive-pattern trigger counter.
- When the optional payload is compiled in, the trigger permanently corrupts the output until reset, giving detection tooling a known-bad article.

Parameters:
- TRIG_PATTERN, 4'b1011, input vector {n0,n1,n2,n3} that counts as a trigger match.
- TRIG_COUNT, 3, consecutive matching samples required to arm the trigger (legal range 1..15).

Ports:
- CK  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- n0  input  1  data bit 0; MSB of the 4-bit input vector.
- n1  input  1  data bit 1.
- n2  input  1  data bit 2.
- n3  input  1  data bit 3; LSB of the 4-bit input vector.
- out  output  1  registered function result.

Behaviour:
- Vector convention: V = {n0,n1,n2,n3}, with n0 as the MSB. Written as 4'bABCD, A=n0 and D=n3.
- Golden function: f(V) = (n0 AND n1) OR (n2 XOR n3).
  - f=1 for V = 0001, 0010, 0101, 0110, 1001, 1010, 1100, 1101, 1110, 1111.
  - f=0 for V = 0000, 0011, 0100, 0111, 1000, 1011.
- Reset (reset=0): asynchronous. out=0, match counter cnt=0, armed=0. All state holds while reset is low.
- Release is synchronous in effect: the first state update happens on the first rising CK edge with reset=1.
- Output register: on each rising CK edge, out <= f(V) XOR payload.
  - V is the value sampled at that edge, so latency is 1 edge.
  - Inputs change between edges; out never changes between edges except on async reset.
- Match counter (4 bits, cnt):
  - Rising edge with V==TRIG_PATTERN: cnt <= min(cnt+1, TRIG_COUNT).
  - Rising edge with V!=TRIG_PATTERN: cnt <= 0.
  - Saturates at TRIG_COUNT and never wraps.
- armed flag:
  - Set on the edge where the counter reaches TRIG_COUNT, i.e. V matches and cnt==TRIG_COUNT-1.
  - Sticky: only reset clears it. Later non-matching inputs do not clear it.
- payload = armed (the registered value before the edge). The first corrupted out value appears on the edge after arming.
- Simultaneous events: async reset has priority over any clock edge. An edge that both arms and samples uses the old armed value for out.
- Reset mid-operation: cnt and armed clear immediately. A partial match sequence is discarded.
- No X-propagation tolerance is required; inputs are assumed driven whenever reset=1.

Optional Feature:
- Macro: I11956_PAYLOAD_EN.
- Defined: cnt, armed and payload are implemented exactly as above.
- Undefined:
  - payload is tied to 0.
  - cnt and armed are not implemented (no flops synthesized).
  - out <= f(V) on every edge, permanently.
  - Port list is identical in both builds.

Test Plan:
- Reset: hold reset=0, toggle CK with V=1111 -> out stays 0. Release, drive V=1111 at the next edge -> out=1.
- Truth sweep, payload compiled in but never triggered: apply V=0000..1111 ascending, one per edge. out after each edge matches f(V): 0,1,1,0,0,1,1,0,0,1,1,0,1,1,1,1. Note V=1011 appears only once, so there is no arming.
- Trigger arming (I11956_PAYLOAD_EN defined): apply 1011,1011,1011 -> out=0,0,0; armed set at the 3rd edge. Then apply 0000 -> out=1, and 1100 -> out=0 (inverted).
- Broken sequence: apply 1011,1011,0000,1011,1011 -> no arming; out=0,0,0,0,0. A subsequent 0001 -> out=1.
- Reset mid-operation: arm as in the arming test, assert reset=0 asynchronously between edges -> out=0 immediately. Release, apply 0001 -> out=1 (payload cleared).
- Macro undefined: repeat the arming-test stimulus, then apply 0000 -> out=0. Output always equals f(V).

Source files
------------

// File: rtl/i11956_pattern_monitor.sv
// Registered 4-input Boolean function with a consecutive-pattern trigger.
// Define I11956_PAYLOAD_EN to build the sticky trigger that inverts the output.
module i11956_pattern_monitor #(
  parameter logic [3:0]  TRIG_PATTERN = 4'b1011,
  parameter int unsigned TRIG_COUNT   = 3
) (
  input  logic CK,
  input  logic reset,
  input  logic n0,
  input  logic n1,
  input  logic n2,
  input  logic n3,
  output logic out
);

  // v[3] is n0, v[0] is n3
  function automatic logic golden_f(input logic [3:0] v);
    return (v[3] & v[2]) | (v[1] ^ v[0]);
  endfunction

  if ((TRIG_COUNT < 1) || (TRIG_COUNT > 15) || $isunknown(TRIG_PATTERN)) begin : g_cfg_check
    $error("i11956_pattern_monitor: TRIG_COUNT must be 1..15 and TRIG_PATTERN fully known");
  end

  logic [3:0] vec_s;
  logic       payload_s;
  logic       out_d;
  logic       out_q;

  assign vec_s = {n0, n1, n2, n3};

`ifdef I11956_PAYLOAD_EN
  localparam logic [3:0] TRIG_CNT_L = 4'(TRIG_COUNT);

  logic       match_s;
  logic [3:0] cnt_d;
  logic [3:0] cnt_q;
  logic       armed_d;
  logic       armed_q;

  assign match_s   = (vec_s == TRIG_PATTERN);
  assign payload_s = armed_q;

  // Saturating run-length counter and sticky arm flag
  always_comb begin
    cnt_d   = 4'd0;
    armed_d = armed_q;
    if (match_s) begin
      if (cnt_q >= TRIG_CNT_L) begin
        cnt_d = TRIG_CNT_L;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
      if (cnt_q == (TRIG_CNT_L - 4'd1)) begin
        armed_d = 1'b1;
      end else begin
        armed_d = armed_q;
      end
    end else begin
      cnt_d   = 4'd0;
      armed_d = armed_q;
    end
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      cnt_q   <= 4'd0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end
`else
  assign payload_s = 1'b0;
`endif

  // Output uses the armed value from before this edge
  always_comb begin
    out_d = golden_f(vec_s) ^ payload_s;
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      out_q <= 1'b0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_i11956_pattern_monitor.sv
// Directed plus randomized bench for i11956_pattern_monitor against a run-length reference model.
module tb_i11956_pattern_monitor;

  logic CK = 1'b0;
  logic reset;
  logic n0, n1, n2, n3;
  logic out;

  int vectors     = 0;
  int miscompares = 0;

  // Reference: truth table from the function's listed values, run length of matches.
  logic [15:0] f_tbl = 16'b1111_0110_0110_0110; // bit i = f(i)
  int          run_m;
  logic        armed_m;
  logic        exp_out;

  i11956_pattern_monitor dut (
    .CK   (CK),
    .reset(reset),
    .n0   (n0),
    .n1   (n1),
    .n2   (n2),
    .n3   (n3),
    .out  (out)
  );

  always #5 CK = ~CK;

  task automatic check(input string tag);
    vectors++;
    assert (out === exp_out)
    else begin
      miscompares++;
      $error("FAIL %s: out=%0b expected %0b", tag, out, exp_out);
    end
  endtask

  task automatic model_reset();
    run_m   = 0;
    armed_m = 1'b0;
    exp_out = 1'b0;
  endtask

  // Drive V at the falling edge, predict, sample 1 time unit after the rising edge.
  task automatic step(input logic [3:0] v, input string tag);
    @(negedge CK);
    {n0, n1, n2, n3} = v;
`ifdef I11956_PAYLOAD_EN
    exp_out = f_tbl[v] ^ armed_m;
    if (v == 4'b1011) run_m++;
    else run_m = 0;
    if (run_m >= 3) armed_m = 1'b1;
`else
    exp_out = f_tbl[v];
`endif
    @(posedge CK);
    #1;
    check(tag);
  endtask

  task automatic async_reset_pulse(input string tag);
    @(negedge CK);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check(tag);
    @(negedge CK);
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] rv;
    reset = 1'b0;
    {n0, n1, n2, n3} = 4'b1111;
    model_reset();

    // Held in reset with V=1111: output stays low across edges
    #1;
    check("reset_init");
    for (int i = 0; i < 3; i++) begin
      @(posedge CK);
      #1;
      check("reset_hold");
    end
    @(negedge CK);
    reset = 1'b1;
    step(4'b1111, "release_1111");

    // Ascending truth sweep; 1011 appears once so nothing arms
    for (int v = 0; v < 16; v++) begin
      step(4'(v), "sweep");
    end

    // Arming sequence, then inverted (or plain) outputs
    step(4'b1011, "arm_1");
    step(4'b1011, "arm_2");
    step(4'b1011, "arm_3");
    step(4'b0000, "armed_0000");
    step(4'b1100, "armed_1100");

    // Asynchronous reset between edges clears payload
    async_reset_pulse("midreset_out");
    step(4'b0001, "post_reset_0001");

    // Broken run of matches never arms
    step(4'b1011, "broken_1");
    step(4'b1011, "broken_2");
    step(4'b0000, "broken_3");
    step(4'b1011, "broken_4");
    step(4'b1011, "broken_5");
    step(4'b0001, "broken_after");

    // Longer run past the trigger count, then non-matching inputs
    for (int i = 0; i < 5; i++) step(4'b1011, "long_run");
    for (int v = 0; v < 16; v++) step(4'(v), "armed_sweep");
    async_reset_pulse("midreset_2");

    // Randomized stimulus biased toward the trigger pattern
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) rv = 4'b1011;
      else rv = 4'($urandom_range(0, 15));
      step(rv, "random");
      if ($urandom_range(0, 60) == 0) async_reset_pulse("random_reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
